// File: rtl/ks_multiword_add_seq.sv
// Multi-word add/subtract sequencer that time-shares one external N-bit Kogge-Stone adder.
// Optional macro KS_SEQ_ZERO_FLAG_EN adds the o_resp_zero result flag.
module ks_multiword_add_seq #(
    parameter int N     = 16,
    parameter int WORDS = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [N*WORDS-1:0] i_req_a,
    input  logic [N*WORDS-1:0] i_req_b,
    input  logic               i_req_sub,
    input  logic               i_req_cin,
    output logic [N-1:0]       o_add_a,
    output logic [N-1:0]       o_add_b,
    output logic               o_add_cin,
    input  logic [N-1:0]       i_add_sum,
    input  logic               i_add_cout,
    output logic               o_resp_valid,
    input  logic               i_resp_ready,
    output logic [N*WORDS-1:0] o_resp_sum,
    output logic               o_resp_cout,
    output logic               o_resp_ovf,
`ifdef KS_SEQ_ZERO_FLAG_EN
    output logic               o_resp_zero,
`endif
    output logic               o_busy
);

    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]               r_state;
    logic [IDXW-1:0]          r_idx;
    logic                     r_carry;
    logic [WORDS-1:0][N-1:0]  r_a;
    logic [WORDS-1:0][N-1:0]  r_b;
    logic [WORDS-1:0][N-1:0]  r_sum;
    logic                     r_cout;
    logic                     r_ovf;

    logic                     w_run;
    logic                     w_last;
    logic                     w_ovf;

    assign w_run  = (r_state == S_RUN);
    assign w_last = (r_idx == IDXW'(WORDS - 1));
    // Signed overflow is judged on the top word only, using the operand MSBs and the top sum bit.
    assign w_ovf  = (r_a[WORDS-1][N-1] == r_b[WORDS-1][N-1]) &&
                    (i_add_sum[N-1] != r_a[WORDS-1][N-1]);

    assign o_add_a      = w_run ? r_a[r_idx] : '0;
    assign o_add_b      = w_run ? r_b[r_idx] : '0;
    assign o_add_cin    = w_run ? r_carry    : 1'b0;

    assign o_req_ready  = (r_state == S_IDLE);
    assign o_busy       = (r_state != S_IDLE);
    assign o_resp_valid = (r_state == S_DONE);
    assign o_resp_sum   = r_sum;
    assign o_resp_cout  = r_cout;
    assign o_resp_ovf   = r_ovf;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        // Subtraction is A + ~B + 1, so invert B and seed the carry here.
                        r_a     <= i_req_a;
                        r_b     <= i_req_sub ? ~i_req_b : i_req_b;
                        r_carry <= i_req_sub ? 1'b1 : i_req_cin;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[r_idx] <= i_add_sum;
                    r_carry      <= i_add_cout;
                    r_idx        <= r_idx + 1'b1;
                    if (w_last) begin
                        r_cout  <= i_add_cout;
                        r_ovf   <= w_ovf;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef KS_SEQ_ZERO_FLAG_EN
    logic r_zero;

    // Zero detection accumulates one word per RUN cycle instead of reducing the full result.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_zero <= 1'b0;
        end else if ((r_state == S_IDLE) && i_req_valid) begin
            r_zero <= 1'b1;
        end else if (w_run) begin
            r_zero <= r_zero & (i_add_sum == '0);
        end
    end

    assign o_resp_zero = r_zero & o_resp_valid;
`endif

endmodule

// File: tb/tb_ks_multiword_add_seq.sv
// Self-checking bench for ks_multiword_add_seq with a behavioural stand-in for the external adder.
// Checks o_resp_zero only when KS_SEQ_ZERO_FLAG_EN is defined.
module tb_ks_multiword_add_seq;

    localparam int N     = 16;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic         clk = 1'b0;
    logic         rstN;
    logic         reqValid;
    logic         reqReady;
    logic [W-1:0] reqA;
    logic [W-1:0] reqB;
    logic         reqSub;
    logic         reqCin;
    logic [N-1:0] addA;
    logic [N-1:0] addB;
    logic         addCin;
    logic [N-1:0] addSum;
    logic         addCout;
    logic         respValid;
    logic         respReady;
    logic [W-1:0] respSum;
    logic         respCout;
    logic         respOvf;
    logic         busy;
`ifdef KS_SEQ_ZERO_FLAG_EN
    logic         respZero;
`endif

    exp_t sbQ[$];
    int   nCompared   = 0;
    int   nMismatched = 0;
    logic cinSeen [0:WORDS-1];
    int   lat;

    always #5 clk = ~clk;

    // Behavioural model of the external combinational adder.
    assign {addCout, addSum} = {1'b0, addA} + {1'b0, addB} + {{N{1'b0}}, addCin};

    ks_multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_req_valid  (reqValid),
        .o_req_ready  (reqReady),
        .i_req_a      (reqA),
        .i_req_b      (reqB),
        .i_req_sub    (reqSub),
        .i_req_cin    (reqCin),
        .o_add_a      (addA),
        .o_add_b      (addB),
        .o_add_cin    (addCin),
        .i_add_sum    (addSum),
        .i_add_cout   (addCout),
        .o_resp_valid (respValid),
        .i_resp_ready (respReady),
        .o_resp_sum   (respSum),
        .o_resp_cout  (respCout),
        .o_resp_ovf   (respOvf),
`ifdef KS_SEQ_ZERO_FLAG_EN
        .o_resp_zero  (respZero),
`endif
        .o_busy       (busy)
    );

    // Full-width reference result, independent of the word-serial datapath.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic cin);
        exp_t         e;
        logic [W-1:0] be;
        logic [W:0]   full;
        be     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
        e.zero = (full[W-1:0] == '0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one request at a negedge; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin, input bit keepValid);
        for (int i = 0; i < 30 && !reqReady; i++) @(negedge clk);
        check("req_ready_before_accept", 64'(reqReady), 64'(1));
        reqA     = a;
        reqB     = b;
        reqSub   = sub;
        reqCin   = cin;
        reqValid = 1'b1;
        @(posedge clk);
        sbQ.push_back(model(a, b, sub, cin));
        #1;
        if (!keepValid) reqValid = 1'b0;
    endtask

    task automatic waitResp();
        lat = 0;
        for (int i = 0; i < WORDS; i++) cinSeen[i] = 1'bx;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lat++;
            if (lat <= WORDS) cinSeen[lat-1] = addCin;
            if (respValid) break;
        end
        check("resp_latency", 64'(lat), 64'(WORDS + 1));
    endtask

    task automatic checkOutput();
        exp_t e;
        check("sb_nonempty", 64'(sbQ.size() != 0), 64'(1));
        if (sbQ.size() != 0) begin
            e = sbQ.pop_front();
            check("resp_valid", 64'(respValid), 64'(1));
            check("resp_sum",   64'(respSum),   64'(e.sum));
            check("resp_cout",  64'(respCout),  64'(e.cout));
            check("resp_ovf",   64'(respOvf),   64'(e.ovf));
`ifdef KS_SEQ_ZERO_FLAG_EN
            check("resp_zero",  64'(respZero),  64'(e.zero));
`endif
        end
    endtask

    task automatic finishResp();
        respReady = 1'b1;
        @(posedge clk);
        #1;
        respReady = 1'b0;
        check("resp_valid_drop", 64'(respValid), 64'(0));
        @(negedge clk);
    endtask

    task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic cin);
        applyStimulus(a, b, sub, cin, 1'b0);
        waitResp();
        checkOutput();
        finishResp();
    endtask

    initial begin
        rstN      = 1'b0;
        reqValid  = 1'b0;
        reqA      = '0;
        reqB      = '0;
        reqSub    = 1'b0;
        reqCin    = 1'b0;
        respReady = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        @(negedge clk);

        $display("[TB] reset state");
        check("rst_req_ready",  64'(reqReady),  64'(1));
        check("rst_resp_valid", 64'(respValid), 64'(0));
        check("rst_resp_sum",   64'(respSum),   64'(0));
        check("rst_resp_cout",  64'(respCout),  64'(0));
        check("rst_resp_ovf",   64'(respOvf),   64'(0));
        check("rst_busy",       64'(busy),      64'(0));
        check("rst_add_a",      64'(addA),      64'(0));
        check("rst_add_cin",    64'(addCin),    64'(0));

        $display("[TB] carry across word 0");
        applyStimulus(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
        check("run_busy", 64'(busy), 64'(1));
        waitResp();
        check("cin_word0", 64'(cinSeen[0]), 64'(0));
        check("cin_word1", 64'(cinSeen[1]), 64'(1));
        check("cin_word2", 64'(cinSeen[2]), 64'(0));
        check("cin_word3", 64'(cinSeen[3]), 64'(0));
        check("tp1_sum", 64'(respSum), 64'h0000_0000_0001_0000);
        checkOutput();
        finishResp();
        check("idle_add_cin", 64'(addCin), 64'(0));

        $display("[TB] full-width wrap and subtraction edges");
        runOp(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        runOp(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0);
        runOp(64'h0, 64'h1, 1'b1, 1'b0);
        runOp(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1);
        runOp(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);

        $display("[TB] backpressure");
        applyStimulus(64'h0000_1111_2222_3333, 64'h0000_0000_4444_5555, 1'b1, 1'b0, 1'b1);
        waitResp();
        for (int i = 0; i < 10; i++) begin
            check("bp_resp_valid", 64'(respValid), 64'(1));
            check("bp_req_ready",  64'(reqReady),  64'(0));
            check("bp_resp_sum",   64'(respSum),   64'(sbQ[0].sum));
            @(negedge clk);
        end
        checkOutput();
        respReady = 1'b1;
        @(posedge clk);
        #1;
        respReady = 1'b0;
        check("bp_idle_ready", 64'(reqReady),  64'(1));
        check("bp_idle_valid", 64'(respValid), 64'(0));
        @(posedge clk);
        sbQ.push_back(model(reqA, reqB, reqSub, reqCin));
        #1;
        reqValid = 1'b0;
        check("bp_reaccept_busy", 64'(busy), 64'(1));
        waitResp();
        checkOutput();
        finishResp();

        $display("[TB] reset mid-operation");
        applyStimulus(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("midrst_idx2_add_a", 64'(addA), 64'hBBBB);
        rstN = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        sbQ.delete();
        @(negedge clk);
        check("midrst_req_ready",  64'(reqReady),  64'(1));
        check("midrst_resp_valid", 64'(respValid), 64'(0));
        check("midrst_resp_sum",   64'(respSum),   64'(0));
        check("midrst_busy",       64'(busy),      64'(0));
        applyStimulus(64'd3, 64'd4, 1'b0, 1'b0, 1'b0);
        waitResp();
        check("after_rst_sum", 64'(respSum), 64'd7);
        checkOutput();
        finishResp();

        $display("[TB] zero results");
        runOp(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);
        runOp(64'h0000_0001_0000_0000, 64'h0, 1'b1, 1'b0);

        check("sb_drained", 64'(sbQ.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/ks_multiword_add_seq.md
Name: ks_multiword_add_seq

Overview:
Sequencer that performs W-bit add/subtract operations on a single shared N-bit Kogge-Stone adder by iterating over the operand words, least-significant word first, and chaining the carry between iterations. It sits between a requesting datapath (valid/ready handshake) and one instance of the combinational N-bit adder, which is external and reached through the add_* ports. Only one operation is in flight at a time.

Parameters:
N, 16, width of the external adder in bits (≥ 2)
WORDS, 4, number of N-bit words per operand (≥ 1); W = N*WORDS

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_a  input  W  operand A
req_b  input  W  operand B
req_sub  input  1  1 = A − B, 0 = A + B + req_cin
req_cin  input  1  carry-in, used only when req_sub = 0
add_a  output  N  current word of A to the adder
add_b  output  N  current word of effective B to the adder
add_cin  output  1  carry into the adder
add_sum  input  N  adder sum, combinational from add_a/add_b/add_cin
add_cout  input  1  adder carry-out
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts result
resp_sum  output  W  result
resp_cout  output  1  final carry-out; for subtraction, 1 = no borrow
resp_ovf  output  1  signed two's-complement overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Reset: rst_n sampled low at a rising edge → state IDLE, idx=0, carry=0, resp_valid=0, resp_sum=0, resp_cout=0, resp_ovf=0, busy=0. All operand/result registers are cleared. Reset applies in every state, including mid-RUN and DONE; any in-flight operation is discarded and never produces a response.
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1, busy=0.
  - On req_valid=1, latch the request:
    - a_reg=req_a;
    - b_reg=~req_b if req_sub, else req_b;
    - carry=1 if req_sub, else req_cin;
    - idx=0.
  - Then go to RUN.
- RUN:
  - req_ready=0, busy=1.
  - Each cycle, drive add_a=a_reg[idx*N +: N], add_b=b_reg[idx*N +: N], add_cin=carry.
  - At the edge: result[idx*N +: N] ← add_sum; carry ← add_cout; idx ← idx+1.
  - When idx = WORDS−1 at the edge, go to DONE and register resp_cout=add_cout.
  - Register resp_ovf = (a_msb == b_msb) && (add_sum[N−1] != a_msb), where a_msb and b_msb are the MSBs of a_reg and effective b_reg.
  - WORDS=1 gives exactly one RUN cycle.
- DONE:
  - resp_valid=1; resp_sum, resp_cout and resp_ovf are held stable.
  - On resp_ready=1, go to IDLE and drop resp_valid at that edge.
- add_a, add_b and add_cin are 0 outside RUN.
- Latency: request accepted at edge E0 → resp_valid high in the cycle after edge E0+WORDS (WORDS RUN cycles). Minimum spacing between accepts is WORDS+2 cycles.
- req_valid is ignored while busy. req_a, req_b, req_sub and req_cin need only be valid in the accept cycle.
- resp_ready is ignored unless in DONE.
- The adder is purely combinational. No registered path through it is assumed; add_sum is sampled in the same cycle add_a is driven.
- Arithmetic is modulo 2^W. resp_cout is the carry out of bit W−1.

Optional Feature:
KS_SEQ_ZERO_FLAG_EN
- Defined: an extra output resp_zero (1 bit) is added. It is 1 in DONE when resp_sum == 0 and is reset to 0.
  - It is computed incrementally: a flag is set on accept and ANDed with (add_sum == 0) each RUN cycle. No W-bit reduction is performed in DONE.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- N=16, WORDS=4, add A=0x0000_0000_0000_FFFF, B=1, cin=0, accept at cycle 0 → resp_valid at cycle 5; sum=0x0000_0000_0001_0000, cout=0, ovf=0. add_cin must be 0,1,0,0 across the RUN cycles.
- Add A=0xFFFF_FFFF_FFFF_FFFF, B=0x0000_0000_0000_0001, cin=0 → sum=0, cout=1, ovf=0.
- Subtract A=0x8000_0000_0000_0000, B=1 → sum=0x7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1. Also subtract A=0, B=1 → sum=all ones, cout=0, ovf=0.
- Backpressure: hold resp_ready=0 for 10 cycles after resp_valid with req_valid=1 throughout → resp_* stable, req_ready=0, no second accept. On resp_ready=1 → IDLE next cycle, accept the following cycle.
- Reset mid-op: assert rst_n=0 for one edge when idx=2 → next cycle IDLE, req_ready=1, resp_valid=0, resp_sum=0. A subsequent add 3+4 → sum=7, no residue from the aborted operation.
- With KS_SEQ_ZERO_FLAG_EN: subtract 0x1234_5678_9ABC_DEF0 − same value → sum=0, resp_zero=1, cout=1. Then 0x1_0000_0000 − 0 → resp_zero=0 (nonzero only in word 2).
